// File: rtl/instr_enc_pkg.sv
// Shared definitions for the instruction encoder/loader.
//   op_e     : symbolic operation class carried on the request bus
//   OPC_* / FN_* : 6-bit MIPS opcode and funct constants (also used by the
//              MainControl bench to build its decode expectations)
//   state_e  : loader FSM state
package instr_enc_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'd0,
    OP_SUB     = 4'd1,
    OP_AND     = 4'd2,
    OP_OR      = 4'd3,
    OP_SLT     = 4'd4,
    OP_ADDI    = 4'd5,
    OP_ANDI    = 4'd6,
    OP_ORI     = 4'd7,
    OP_SLTI    = 4'd8,
    OP_LW      = 4'd9,
    OP_SW      = 4'd10,
    OP_BEQ     = 4'd11,
    OP_BNE     = 4'd12,
    OP_J       = 4'd13,
    OP_JAL     = 4'd14,
    OP_ILLEGAL = 4'd15
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request bus of the instruction encoder/loader: valid/ready handshake plus
// the symbolic instruction fields.
//   master : request producer (drives valid and fields, observes ready)
//   slave  : encoder side (observes valid and fields, drives ready)
// in_op is carried as raw bits so a producer can present the illegal code 15.
interface instr_encoder_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic        in_last;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_op, in_last, in_rs, in_rt, in_rd, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_last, in_rs, in_rt, in_rd, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/instr_field_pack.sv
// Purely combinational MIPS field packer: op class + register/immediate
// fields -> 32-bit instruction word, plus a flag for the illegal op code.
//   op      : operation class (instr_enc_pkg::op_e encoding)
//   rs/rt/rd: register fields (rd used by R-type only)
//   imm     : 16-bit immediate / branch offset, copied verbatim
//   target  : 26-bit jump target (J/JAL only; rs/rt are dropped)
//   word    : encoded instruction, zero for an illegal op
//   illegal : op has no encoding
module instr_field_pack
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op_e'(op))
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      OP_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      OP_ADDI: word = {OPC_ADDI, rs, rt, imm};
      OP_ANDI: word = {OPC_ANDI, rs, rt, imm};
      OP_ORI:  word = {OPC_ORI, rs, rt, imm};
      OP_SLTI: word = {OPC_SLTI, rs, rt, imm};
      OP_LW:   word = {OPC_LW, rs, rt, imm};
      OP_SW:   word = {OPC_SW, rs, rt, imm};
      OP_BEQ:  word = {OPC_BEQ, rs, rt, imm};
      OP_BNE:  word = {OPC_BNE, rs, rt, imm};
      OP_J:    word = {OPC_J, target};
      OP_JAL:  word = {OPC_JAL, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts symbolic instruction requests on a
// valid/ready bus, encodes each into a MIPS word and writes the words to
// consecutive instruction-memory addresses starting at BASE_ADDR.
//   clk, reset : clock and synchronous active-high reset
//   start      : begin a load session (ignored while busy)
//   req        : request bus (slave side)
//   mem_we/mem_addr/mem_wdata : instruction-memory write port, one cycle
//                after each legal accept
//   count      : words written this session
//   busy       : session in progress; done: one-cycle end-of-session pulse
//   err        : sticky illegal-op / overflow flag, cleared by start
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  instr_encoder_loader_if.slave req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_W:0]       count,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_e              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W-1:0]   mem_addr_reg;
  logic [ADDR_W:0]     count_reg;
  logic [31:0]         wdata_reg;
  logic                we_reg;
  logic                done_reg;
  logic                err_reg;
  logic                ready_reg;

  logic [31:0]         enc_word;
  logic                enc_illegal;
  logic                accept;
  logic [ADDR_W:0]     count_next;
  logic                reach_full;

  instr_field_pack u_pack (
    .op      (req.in_op),
    .rs      (req.in_rs),
    .rt      (req.in_rt),
    .rd      (req.in_rd),
    .imm     (req.in_imm),
    .target  (req.in_target),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign accept     = req.in_valid & ready_reg;
  assign count_next = count_reg + (ADDR_W+1)'(1);
  // This accept fills the session; illegal ops never consume a slot.
  assign reach_full = !enc_illegal && (count_next == DEPTH_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= BASE;
      mem_addr_reg <= BASE;
      count_reg    <= '0;
      wdata_reg    <= '0;
      we_reg       <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      ready_reg    <= 1'b0;
    end else begin
      we_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_RUN;
            addr_reg  <= BASE;
            count_reg <= '0;
            err_reg   <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (!enc_illegal) begin
              // Word, address and count are captured together so the
              // write appears exactly one cycle after the accept.
              we_reg       <= 1'b1;
              wdata_reg    <= enc_word;
              mem_addr_reg <= addr_reg;
              addr_reg     <= addr_reg + 1'b1;
              count_reg    <= count_next;
            end
            if (enc_illegal || (reach_full && !req.in_last)) begin
              err_reg <= 1'b1;
            end
            if (req.in_last || reach_full) begin
              state_reg <= ST_FLUSH;
              ready_reg <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          state_reg <= ST_DONE;
          done_reg  <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req.in_ready = ready_reg;
  assign mem_we       = we_reg;
  assign mem_addr     = mem_addr_reg;
  assign mem_wdata    = wdata_reg;
  assign count        = count_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign done         = done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4 so overflow is reachable).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_instr_encoder_loader;
  import instr_enc_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;
  localparam int DEPTH     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader_if ifc ();

  instr_encoder_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .req       (ifc),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Present one request and return at the falling edge of the cycle after
  // the accept (where a legal request's write is visible).
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    int wait_cyc;
    ifc.in_op     = op;
    ifc.in_rs     = rs;
    ifc.in_rt     = rt;
    ifc.in_rd     = rd;
    ifc.in_imm    = imm;
    ifc.in_target = tgt;
    ifc.in_last   = last;
    ifc.in_valid  = 1'b1;
    wait_cyc = 0;
    while (!ifc.in_ready && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!ifc.in_ready) begin
      check("ready_timeout", {31'd0, ifc.in_ready}, 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    $display("req op=%0d rs=%0d rt=%0d rd=%0d imm=0x%04h tgt=0x%07h last=%0b",
             op, rs, rt, rd, imm, tgt, last);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    check({tag, "_addr"}, 32'(mem_addr), addr);
    check({tag, "_data"}, mem_wdata, data);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then step into IDLE.
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] exp_word [15];
  logic [5:0]  exp_opc  [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, n_we, n_rdy;
    logic last;

    exp_word = '{32'h00221820, 32'h00221822, 32'h00221824, 32'h00221825, 32'h0022182A,
                 32'h20221234, 32'h30221234, 32'h34221234, 32'h28221234, 32'h8C221234,
                 32'hAC221234, 32'h10221234, 32'h14221234, 32'h0A345678, 32'h0E345678};
    exp_opc  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A,
                 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    ifc.in_valid = 1'b0; ifc.in_op = '0; ifc.in_last = 1'b0;
    ifc.in_rs = '0; ifc.in_rt = '0; ifc.in_rd = '0; ifc.in_imm = '0; ifc.in_target = '0;
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", 32'(mem_addr), 32'(BASE_ADDR));
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single ADD, exact done timing
    do_start();
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_ready", {31'd0, ifc.in_ready}, 32'd1);
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
    expect_write("add", 32'd0, 32'h00221820);
    check("add_count", 32'(count), 32'd1);
    @(negedge clk);
    check("add_done_hi", {31'd0, done}, 32'd1);
    check("add_busy_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("add_done_lo", {31'd0, done}, 32'd0);
    check("add_busy_idle", {31'd0, busy}, 32'd0);

    // Back-to-back LW, BEQ
    do_start();
    send(OP_LW, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b0);
    expect_write("lw", 32'd0, 32'h8FA80004);
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1);
    expect_write("beq", 32'd1, 32'h1022FFFF);
    @(negedge clk);
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_count", 32'(count), 32'd2);
    @(negedge clk);

    // JAL
    do_start();
    send(OP_JAL, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0100000, 1'b1);
    expect_write("jal", 32'd0, 32'h0C100000);
    wait_done("jal");

    // Illegal mid-stream, start while busy ignored
    do_start();
    send(OP_OR, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
    expect_write("or", 32'd0, 32'h00853025);
    do_start();
    send(4'd15, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0);
    check("ill_we", {31'd0, mem_we}, 32'd0);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_count", 32'(count), 32'd1);
    send(OP_SW, 5'd0, 5'd9, 5'd0, 16'h0008, 26'h0, 1'b1);
    expect_write("sw", 32'd1, 32'hAC090008);
    wait_done("sw");
    check("err_sticky", {31'd0, err}, 32'd1);
    do_start();
    check("err_clear", {31'd0, err}, 32'd0);
    // Illegal op carrying in_last still ends the session
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
    check("ill_last_we", {31'd0, mem_we}, 32'd0);
    wait_done("ill_last");
    check("ill_last_err", {31'd0, err}, 32'd1);
    check("ill_last_count", 32'(count), 32'd0);

    // Sweep of all legal ops in sessions of up to DEPTH words
    for (int i = 0; i < 15; i++) begin
      if (i % 4 == 0) do_start();
      last = ((i % 4) == 3) || (i == 14);
      send(4'(i), 5'd1, 5'd2, 5'd3, 16'h1234, 26'h2345678, last);
      expect_write($sformatf("op%0d", i), 32'(i % 4), exp_word[i]);
      check($sformatf("opc%0d", i), {26'd0, mem_wdata[31:26]}, {26'd0, exp_opc[i]});
      if (last) wait_done($sformatf("sweep%0d", i));
    end

    // Overflow: DEPTH requests without in_last, then a fifth one
    do_start();
    send(OP_ADDI, 5'd0, 5'd0, 5'd0, 16'd0, 26'h0, 1'b0);
    expect_write("ovf0", 32'd0, 32'h20000000);
    send(OP_ADDI, 5'd1, 5'd1, 5'd0, 16'd1, 26'h0, 1'b0);
    expect_write("ovf1", 32'd1, 32'h20210001);
    send(OP_ADDI, 5'd2, 5'd2, 5'd0, 16'd2, 26'h0, 1'b0);
    expect_write("ovf2", 32'd2, 32'h20420002);
    send(OP_ADDI, 5'd3, 5'd3, 5'd0, 16'd3, 26'h0, 1'b0);
    expect_write("ovf3", 32'd3, 32'h20630003);
    check("ovf_ready", {31'd0, ifc.in_ready}, 32'd0);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_count", 32'(count), 32'd4);
    ifc.in_op = OP_ADD; ifc.in_last = 1'b0; ifc.in_valid = 1'b1;
    n_done = 0; n_we = 0; n_rdy = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
      if (mem_we) n_we++;
      if (ifc.in_ready) n_rdy++;
    end
    ifc.in_valid = 1'b0;
    check("ovf_done_pulses", 32'(n_done), 32'd1);
    check("ovf_extra_writes", 32'(n_we), 32'd0);
    check("ovf_extra_ready", 32'(n_rdy), 32'd0);
    check("ovf_err_after", {31'd0, err}, 32'd1);

    // Reset coinciding with an accept drops the write
    do_start();
    ifc.in_op = OP_ADD; ifc.in_rs = 5'd1; ifc.in_rt = 5'd2; ifc.in_rd = 5'd3;
    ifc.in_last = 1'b0; ifc.in_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ifc.in_valid = 1'b0;
    check("rstmid_we", {31'd0, mem_we}, 32'd0);
    check("rstmid_addr", 32'(mem_addr), 32'(BASE_ADDR));
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_ready", {31'd0, ifc.in_ready}, 32'd0);

    // start and reset together: reset wins
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rststart_busy", {31'd0, busy}, 32'd0);
    check("rststart_ready", {31'd0, ifc.in_ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
